// File: rtl/sim_exit_monitor_pkg.sv
// Shared types and constants for the simulation exit monitor.
// Imported by the reset sequencer and the monitor top level.
package sim_exit_monitor_pkg;

    typedef enum logic [1:0] {
        STATUS_NONE    = 2'd0,
        STATUS_PASS    = 2'd1,
        STATUS_FAIL    = 2'd2,
        STATUS_TIMEOUT = 2'd3
    } status_e;

    typedef enum logic [1:0] {
        ST_HOLD = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int EXIT_ANY = 0;
    localparam int EXIT_ALL = 1;

    // Width of a channel index; a single channel still needs one bit.
    function automatic int fail_ch_width(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

endpackage

// File: rtl/sim_rst_seq.sv
// Reset-release sequencer: holds sys_rst_no low for RESET_WAIT_CYCLES edges
// after rst_i deasserts, then releases the DUT and raises run_o.
module sim_rst_seq
    import sim_exit_monitor_pkg::*;
#(
    parameter int RESET_WAIT_CYCLES = 50
) (
    input  logic clk_i,
    input  logic rst_i,
    output logic sys_rst_no,
    output logic run_o
);

    localparam int HOLD_W = (RESET_WAIT_CYCLES >= 1) ? $clog2(RESET_WAIT_CYCLES + 1) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_WAIT_CYCLES - 1);

    if (RESET_WAIT_CYCLES < 1) begin : g_bad_wait
        $error("sim_rst_seq: RESET_WAIT_CYCLES must be at least 1");
    end

    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic              released_q, released_d;

    always_comb begin
        hold_cnt_d = hold_cnt_q;
        released_d = released_q;
        if (!released_q) begin
            hold_cnt_d = hold_cnt_q + HOLD_W'(1);
            // Counter value k is seen on edge k+1, so the match releases on edge RESET_WAIT_CYCLES.
            if (hold_cnt_q == HOLD_LAST) begin
                released_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hold_cnt_q <= '0;
            released_q <= 1'b0;
        end else begin
            hold_cnt_q <= hold_cnt_d;
            released_q <= released_d;
        end
    end

    assign sys_rst_no = released_q;
    assign run_o      = released_q;

endmodule

// File: rtl/sim_exit_monitor.sv
// Run-control block: reset sequencing, RUN cycle counter, watchdog and
// per-channel exit detection, producing a sticky registered verdict.
module sim_exit_monitor
    import sim_exit_monitor_pkg::*;
#(
    parameter int          NUM_CH            = 4,
    parameter int          VALUE_W           = 32,
    parameter int          CNT_W             = 32,
    parameter int          RESET_WAIT_CYCLES = 50,
    parameter int unsigned MAX_CYCLES_DEF    = 0,
    parameter int          EXIT_MODE         = 0
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic                              max_cycles_valid_i,
    input  logic [CNT_W-1:0]                  max_cycles_i,
    input  logic [NUM_CH-1:0]                 exit_valid_i,
    input  logic [NUM_CH*VALUE_W-1:0]         exit_value_i,
    output logic                              sys_rst_no,
    output logic [CNT_W-1:0]                  cycle_cnt_o,
    output logic [NUM_CH-1:0]                 ch_done_o,
    output logic                              done_o,
    output logic [1:0]                        status_o,
    output logic [fail_ch_width(NUM_CH)-1:0]  fail_ch_o,
    output logic [VALUE_W-1:0]                fail_value_o
);

    localparam int               FCH_W   = fail_ch_width(NUM_CH);
    localparam logic [CNT_W-1:0] MAX_DEF = CNT_W'(MAX_CYCLES_DEF);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    if (NUM_CH < 1) begin : g_bad_ch
        $error("sim_exit_monitor: NUM_CH must be at least 1");
    end
    if (EXIT_MODE != EXIT_ANY && EXIT_MODE != EXIT_ALL) begin : g_bad_mode
        $error("sim_exit_monitor: EXIT_MODE must be 0 (ANY) or 1 (ALL)");
    end

    logic run;

    sim_rst_seq #(
        .RESET_WAIT_CYCLES(RESET_WAIT_CYCLES)
    ) u_rst_seq (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .sys_rst_no(sys_rst_no),
        .run_o     (run)
    );

    state_e                           state_q, state_d;
    logic [CNT_W-1:0]                 cycle_cnt_q, cycle_cnt_d;
    logic [NUM_CH-1:0]                ch_done_q, ch_done_d;
    logic [NUM_CH-1:0][VALUE_W-1:0]   val_q, val_d;
    logic                             done_q, done_d;
    status_e                          status_q, status_d;
    logic [FCH_W-1:0]                 fail_ch_q, fail_ch_d;
    logic [VALUE_W-1:0]               fail_value_q, fail_value_d;

    logic                             in_run;
    logic [CNT_W-1:0]                 limit;
    logic [NUM_CH-1:0]                new_strobe;
    logic [NUM_CH-1:0]                ch_done_next;
    logic                             finish;
    logic                             bad;
    logic [FCH_W-1:0]                 bad_ch;
    logic [VALUE_W-1:0]               bad_val;
    logic                             cand_vld;
    logic [VALUE_W-1:0]               cand_val;

    // Exit qualification and verdict selection, evaluated every cycle.
    always_comb begin
        limit        = max_cycles_valid_i ? max_cycles_i : MAX_DEF;
        new_strobe   = exit_valid_i & ~ch_done_q;
        ch_done_next = ch_done_q | exit_valid_i;
        finish       = (EXIT_MODE == EXIT_ALL) ? (&ch_done_next) : (|new_strobe);
        bad          = 1'b0;
        bad_ch       = '0;
        bad_val      = '0;
        cand_vld     = 1'b0;
        cand_val     = '0;
        // Scan downward so the lowest failing index is the one left standing.
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            cand_val = new_strobe[k] ? exit_value_i[k*VALUE_W +: VALUE_W] : val_q[k];
            cand_vld = (EXIT_MODE == EXIT_ALL) ? 1'b1 : new_strobe[k];
            if (cand_vld && (cand_val != '0)) begin
                bad     = 1'b1;
                bad_ch  = FCH_W'(k);
                bad_val = cand_val;
            end
        end
    end

    // Sequencer release is seen while still in HOLD, so that cycle already counts as RUN.
    assign in_run = (state_q == ST_RUN) || ((state_q == ST_HOLD) && run);

    always_comb begin
        state_d      = state_q;
        cycle_cnt_d  = cycle_cnt_q;
        ch_done_d    = ch_done_q;
        val_d        = val_q;
        done_d       = done_q;
        status_d     = status_q;
        fail_ch_d    = fail_ch_q;
        fail_value_d = fail_value_q;

        if (in_run) begin
            state_d     = ST_RUN;
            cycle_cnt_d = (cycle_cnt_q == CNT_MAX) ? cycle_cnt_q : cycle_cnt_q + CNT_W'(1);
            ch_done_d   = ch_done_next;
            for (int k = 0; k < NUM_CH; k++) begin
                if (new_strobe[k]) begin
                    val_d[k] = exit_value_i[k*VALUE_W +: VALUE_W];
                end
            end

            if (finish) begin
                state_d      = ST_DONE;
                done_d       = 1'b1;
                status_d     = bad ? STATUS_FAIL : STATUS_PASS;
                fail_ch_d    = bad ? bad_ch : '0;
                fail_value_d = bad ? bad_val : '0;
            end else if ((limit != '0) && (cycle_cnt_q >= limit)) begin
                state_d      = ST_DONE;
                done_d       = 1'b1;
                status_d     = STATUS_TIMEOUT;
                fail_ch_d    = '0;
                fail_value_d = '0;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= ST_HOLD;
            cycle_cnt_q  <= '0;
            ch_done_q    <= '0;
            val_q        <= '0;
            done_q       <= 1'b0;
            status_q     <= STATUS_NONE;
            fail_ch_q    <= '0;
            fail_value_q <= '0;
        end else begin
            state_q      <= state_d;
            cycle_cnt_q  <= cycle_cnt_d;
            ch_done_q    <= ch_done_d;
            val_q        <= val_d;
            done_q       <= done_d;
            status_q     <= status_d;
            fail_ch_q    <= fail_ch_d;
            fail_value_q <= fail_value_d;
        end
    end

    assign cycle_cnt_o  = cycle_cnt_q;
    assign ch_done_o    = ch_done_q;
    assign done_o       = done_q;
    assign status_o     = status_q;
    assign fail_ch_o    = fail_ch_q;
    assign fail_value_o = fail_value_q;

endmodule
